lcd_frame_ctrl: RTL and testbench



---
 rtl/lcd_pkg.sv | 70 +++++++
 rtl/lcd_bus_writer.sv | 107 ++++++++++
 rtl/lcd_frame_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_lcd_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
//------------------------------------------------------------------------------
// Module   : lcd_pkg
// Brief    : Shared types, LCD command bytes, template field positions and
//            helper functions for the LCD frame controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lcd_pkg;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_PWRUP   = 4'd0,
    ST_INIT    = 4'd1,
    ST_HOME1   = 4'd2,
    ST_FETCH   = 4'd3,
    ST_ROMWAIT = 4'd4,
    ST_CHAR    = 4'd5,
    ST_HOME2   = 4'd6,
    ST_DONE    = 4'd7,
    ST_IDLE    = 4'd8
  } ctrl_state_t;

  // Bus writer phases
  typedef enum logic [2:0] {
    WR_IDLE   = 3'd0,
    WR_SETUP  = 3'd1,
    WR_STROBE = 3'd2,
    WR_HOLD   = 3'd3,
    WR_WAIT   = 3'd4
  } wr_state_t;

  // HD44780 commands
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  // Template character positions that carry live values
  localparam logic [4:0] IDX_ADDR_TENS = 5'd4;
  localparam logic [4:0] IDX_ADDR_ONES = 5'd5;
  localparam logic [4:0] IDX_RW        = 5'd14;
  localparam logic [4:0] IDX_DIN_HI    = 5'd20;
  localparam logic [4:0] IDX_DIN_LO    = 5'd21;
  localparam logic [4:0] IDX_DMEM_HI   = 5'd29;
  localparam logic [4:0] IDX_DMEM_LO   = 5'd30;
  localparam logic [4:0] IDX_LINE1_END = 5'd15;
  localparam logic [4:0] IDX_LAST      = 5'd31;

  // Uppercase hex digit for a nibble
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] i_nib);
    if (i_nib < 4'd10) return 8'h30 + {4'h0, i_nib};
    else               return 8'h37 + {4'h0, i_nib};
  endfunction

  // Initialisation command by position in the init sequence
  function automatic logic [7:0] init_cmd(input logic [1:0] i_pos);
    case (i_pos)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_bus_writer.sv
//------------------------------------------------------------------------------
// Module   : lcd_bus_writer
// Brief    : One LCD bus write: SETUP (1) / STROBE (EN_PULSE_CYC) / HOLD (1) /
//            WAIT (CMD_WAIT_CYC or CLEAR_WAIT_CYC). o_done marks the last
//            WAIT cycle so a new write can start with no bubble.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int EN_PULSE_CYC   = 50,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  input  logic       i_rs,
  input  logic       i_long_wait,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_en,
  output logic       o_done
);

  localparam int C_MAX_A = (CLEAR_WAIT_CYC > CMD_WAIT_CYC) ? CLEAR_WAIT_CYC : CMD_WAIT_CYC;
  localparam int C_MAX   = (C_MAX_A > EN_PULSE_CYC) ? C_MAX_A : EN_PULSE_CYC;
  localparam int CW      = $clog2(C_MAX + 1);

  localparam logic [CW-1:0] C_EN_LAST  = CW'(EN_PULSE_CYC - 1);
  localparam logic [CW-1:0] C_CMD_LAST = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] C_CLR_LAST = CW'(CLEAR_WAIT_CYC - 1);

  wr_state_t     r_state;
  wr_state_t     w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_wait_last;
  logic [7:0]    r_data;
  logic          r_rs;
  logic          r_long;
  logic          r_en;
  logic          w_done;

  assign w_wait_last = r_long ? C_CLR_LAST : C_CMD_LAST;

  // Phase sequencing; a start always (re)enters SETUP
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      WR_SETUP:  w_next = WR_STROBE;
      WR_STROBE: if (r_cnt == C_EN_LAST) w_next = WR_HOLD;
      WR_HOLD:   w_next = WR_WAIT;
      WR_WAIT: begin
        if (r_cnt == w_wait_last) begin
          w_done = 1'b1;
          w_next = WR_IDLE;
        end
      end
      default:   w_next = WR_IDLE;
    endcase
    if (i_start) w_next = WR_SETUP;
  end

  // Phase register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= WR_IDLE;
    else          r_state <= w_next;
  end

  // Cycle counter, restarted on every phase change
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                    r_cnt <= '0;
    else if ((w_next != r_state) || (r_state == WR_IDLE)) r_cnt <= '0;
    else                                             r_cnt <= r_cnt + CW'(1);
  end

  // Byte, RS and wait length are held from SETUP until the next start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= 8'h00;
      r_rs   <= 1'b0;
      r_long <= 1'b0;
    end else if (i_start) begin
      r_data <= i_byte;
      r_rs   <= i_rs;
      r_long <= i_long_wait;
    end
  end

  // Registered enable strobe; async reset drops it immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_en <= 1'b0;
    else          r_en <= (w_next == WR_STROBE);
  end

  assign o_lcd_data = r_data;
  assign o_lcd_rs   = r_rs;
  assign o_lcd_en   = r_en;
  assign o_done     = w_done;

endmodule

`default_nettype wire

// File: rtl/lcd_frame_ctrl.sv
//------------------------------------------------------------------------------
// Module   : lcd_frame_ctrl
// Brief    : 16x2 HD44780 sequencer (8-bit mode). Power-up wait, init
//            commands, then frames of 32 template characters with live
//            address / mode / keypad / memory fields substituted.
// Config   : LCD_AUTO_REFRESH_EN - when defined, frames run back-to-back with
//            a single IDLE cycle between them and refresh is ignored.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_frame_ctrl
  import lcd_pkg::*;
#(
  parameter int POWERUP_WAIT_CYC = 1_000_000,
  parameter int EN_PULSE_CYC     = 50,
  parameter int CMD_WAIT_CYC     = 2500,
  parameter int CLEAR_WAIT_CYC   = 100_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       refresh,
  input  logic [4:0] addr_in,
  input  logic       rw_in,
  input  logic [7:0] data_in,
  input  logic [7:0] data_mem,
  output logic [4:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       busy,
  output logic       frame_done
);

  localparam int            PW        = $clog2(POWERUP_WAIT_CYC + 1);
  localparam logic [PW-1:0] C_PW_LAST = PW'(POWERUP_WAIT_CYC - 1);

  ctrl_state_t   r_state;
  ctrl_state_t   w_next;
  logic [PW-1:0] r_pw_cnt;
  logic [1:0]    r_init_idx;
  logic [4:0]    r_idx;
  logic [4:0]    w_idx_nxt;
  logic [4:0]    r_rom_addr;
  logic [4:0]    r_addr;
  logic          r_rw;
  logic [7:0]    r_din;
  logic [7:0]    r_dmem;
  logic          w_start;
  logic [7:0]    w_byte;
  logic          w_rs;
  logic          w_long;
  logic          w_wr_done;
  logic          w_trigger;
  logic [3:0]    w_tens;
  logic [3:0]    w_ones;
  logic [7:0]    w_char;

`ifdef LCD_AUTO_REFRESH_EN
  logic w_refresh_unused;
  assign w_refresh_unused = refresh;
  assign w_trigger        = 1'b1;
`else
  assign w_trigger = refresh;
`endif

  // Decimal split of the captured address (0..31)
  always_comb begin
    w_tens = 4'd0;
    w_ones = 4'(r_addr);
    if (r_addr >= 5'd30) begin
      w_tens = 4'd3;
      w_ones = 4'(r_addr - 5'd30);
    end else if (r_addr >= 5'd20) begin
      w_tens = 4'd2;
      w_ones = 4'(r_addr - 5'd20);
    end else if (r_addr >= 5'd10) begin
      w_tens = 4'd1;
      w_ones = 4'(r_addr - 5'd10);
    end
  end

  // Character to display: template byte or a live field
  always_comb begin
    w_char = rom_data;
    case (r_idx)
      IDX_ADDR_TENS: w_char = 8'h30 + {4'h0, w_tens};
      IDX_ADDR_ONES: w_char = 8'h30 + {4'h0, w_ones};
      IDX_RW:        w_char = r_rw ? 8'h57 : 8'h52;
      IDX_DIN_HI:    w_char = nibble_to_ascii(r_din[7:4]);
      IDX_DIN_LO:    w_char = nibble_to_ascii(r_din[3:0]);
      IDX_DMEM_HI:   w_char = nibble_to_ascii(r_dmem[7:4]);
      IDX_DMEM_LO:   w_char = nibble_to_ascii(r_dmem[3:0]);
      default:       w_char = rom_data;
    endcase
  end

  // Next state and writer requests; a write is launched on the edge that
  // enters the state owning it, so the writer never idles between writes
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_byte  = 8'h00;
    w_rs    = 1'b0;
    case (r_state)
      ST_PWRUP: begin
        if (r_pw_cnt == C_PW_LAST) begin
          w_next  = ST_INIT;
          w_start = 1'b1;
          w_byte  = CMD_FUNC_SET;
        end
      end
      ST_INIT: begin
        if (w_wr_done) begin
          w_start = 1'b1;
          if (r_init_idx == 2'd3) begin
            w_next = ST_HOME1;
            w_byte = CMD_LINE1;
          end else begin
            w_byte = init_cmd(r_init_idx + 2'd1);
          end
        end
      end
      ST_HOME1, ST_HOME2: begin
        if (w_wr_done) w_next = ST_FETCH;
      end
      ST_FETCH: w_next = ST_ROMWAIT;
      ST_ROMWAIT: begin
        w_next  = ST_CHAR;
        w_start = 1'b1;
        w_rs    = 1'b1;
        w_byte  = w_char;
      end
      ST_CHAR: begin
        if (w_wr_done) begin
          if (r_idx == IDX_LINE1_END) begin
            w_next  = ST_HOME2;
            w_start = 1'b1;
            w_byte  = CMD_LINE2;
          end else if (r_idx == IDX_LAST) begin
            w_next = ST_DONE;
          end else begin
            w_next = ST_FETCH;
          end
        end
      end
      ST_DONE: w_next = ST_IDLE;
      ST_IDLE: begin
        if (w_trigger) begin
          w_next  = ST_HOME1;
          w_start = 1'b1;
          w_byte  = CMD_LINE1;
        end
      end
      default: w_next = ST_PWRUP;
    endcase
  end

  assign w_long = !w_rs && (w_byte == CMD_CLEAR);

  // Character index: cleared for a new frame, advanced after each character
  always_comb begin
    w_idx_nxt = r_idx;
    if (w_next == ST_HOME1)
      w_idx_nxt = 5'd0;
    else if ((r_state == ST_CHAR) && w_wr_done && (r_idx != IDX_LAST))
      w_idx_nxt = r_idx + 5'd1;
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_PWRUP;
    else          r_state <= w_next;
  end

  // Power-up delay counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                   r_pw_cnt <= '0;
    else if (r_state == ST_PWRUP)   r_pw_cnt <= r_pw_cnt + PW'(1);
  end

  // Position within the init command list
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_init_idx <= 2'd0;
    else if ((r_state == ST_INIT) && w_wr_done && (r_init_idx != 2'd3))
      r_init_idx <= r_init_idx + 2'd1;
  end

  // Character index and ROM address (address presented during FETCH)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx      <= 5'd0;
      r_rom_addr <= 5'd0;
    end else begin
      r_idx <= w_idx_nxt;
      if (w_next == ST_FETCH) r_rom_addr <= w_idx_nxt;
    end
  end

  // Live-field snapshot taken once per frame, on entry to HOME1
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= 5'd0;
      r_rw   <= 1'b0;
      r_din  <= 8'h00;
      r_dmem <= 8'h00;
    end else if ((r_state != ST_HOME1) && (w_next == ST_HOME1)) begin
      r_addr <= addr_in;
      r_rw   <= rw_in;
      r_din  <= data_in;
      r_dmem <= data_mem;
    end
  end

  lcd_bus_writer #(
    .EN_PULSE_CYC   (EN_PULSE_CYC),
    .CMD_WAIT_CYC   (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
  ) u_writer (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_start     (w_start),
    .i_byte      (w_byte),
    .i_rs        (w_rs),
    .i_long_wait (w_long),
    .o_lcd_data  (lcd_data),
    .o_lcd_rs    (lcd_rs),
    .o_lcd_en    (lcd_en),
    .o_done      (w_wr_done)
  );

  assign rom_addr   = r_rom_addr;
  assign lcd_rw     = 1'b0;
  assign busy       = (r_state != ST_DONE) && (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_lcd_frame_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_lcd_frame_ctrl
// Brief    : Self-checking bench for lcd_frame_ctrl with short timing
//            parameters, a registered template ROM model and a write
//            scoreboard (byte, RS, strobe-to-strobe spacing).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_lcd_frame_ctrl;

  localparam int PWR  = 10;
  localparam int ENP  = 2;
  localparam int CMDW = 4;
  localparam int CLRW = 8;

  localparam logic [255:0] TMPL = "Ain:##    R/W:# Din:##  Dout:## ";

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b0;
  logic       refresh  = 1'b0;
  logic [4:0] addr_in  = 5'd0;
  logic       rw_in    = 1'b0;
  logic [7:0] data_in  = 8'h00;
  logic [7:0] data_mem = 8'h00;
  logic [4:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, busy, frame_done;

  always #5 clock = ~clock;

  lcd_frame_ctrl #(
    .POWERUP_WAIT_CYC (PWR),
    .EN_PULSE_CYC     (ENP),
    .CMD_WAIT_CYC     (CMDW),
    .CLEAR_WAIT_CYC   (CLRW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .refresh    (refresh),
    .addr_in    (addr_in),
    .rw_in      (rw_in),
    .data_in    (data_in),
    .data_mem   (data_mem),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Registered template ROM
  always @(posedge clock) rom_data <= TMPL[255 - 8*rom_addr -: 8];

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;       // expected cycles since previous strobe (0 = unchecked)
    bit         from_rel;  // measure from reset release instead
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0, rel_cyc = 0, last_rise = 0, strobes = 0, fd_count = 0, hi_cnt = 0;
  int   strobes_snap = 0;
  logic prev_en = 1'b0;
  bit   pending = 1'b0;
  logic [8:0] cap;

  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n <= 4'd9) return 8'd48 + 8'(n);
    return 8'd65 + 8'(n) - 8'd10;
  endfunction

  function automatic logic [7:0] exp_char(input int i, input logic [4:0] a, input logic w,
                                          input logic [7:0] di, input logic [7:0] dm);
    case (i)
      4:       return 8'd48 + 8'(a / 10);
      5:       return 8'd48 + 8'(a % 10);
      14:      return w ? 8'h57 : 8'h52;
      20:      return hexc(di[7:4]);
      21:      return hexc(di[3:0]);
      29:      return hexc(dm[7:4]);
      30:      return hexc(dm[3:0]);
      default: return TMPL[255 - 8*i -: 8];
    endcase
  endfunction

  task automatic push(input logic rs, input logic [7:0] d, input int gap, input bit from_rel);
    exp_t e;
    e.rs = rs; e.data = d; e.gap = gap; e.from_rel = from_rel;
    sb.push_back(e);
  endtask

  task automatic push_init();
    push(1'b0, 8'h38, PWR + 1, 1'b1);
    push(1'b0, 8'h0C, ENP + CMDW + 2, 1'b0);
    push(1'b0, 8'h01, ENP + CMDW + 2, 1'b0);
    push(1'b0, 8'h06, ENP + CLRW + 2, 1'b0);
  endtask

  task automatic push_frame(input int first_gap, input logic [4:0] a, input logic w,
                            input logic [7:0] di, input logic [7:0] dm);
    push(1'b0, 8'h80, first_gap, 1'b0);
    for (int i = 0; i < 32; i++) begin
      if (i == 16) push(1'b0, 8'hC0, ENP + CMDW + 2, 1'b0);
      push(1'b1, exp_char(i, a, w, di, dm), ENP + CMDW + 4, 1'b0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_lcd_data"}, 32'(lcd_data), 32'h00);
    check({tag, "_lcd_rs"}, 32'(lcd_rs), 32'd0);
    check({tag, "_lcd_rw"}, 32'(lcd_rw), 32'd0);
    check({tag, "_lcd_en"}, 32'(lcd_en), 32'd0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  task automatic wait_fd(input int target, input int budget);
    int n = 0;
    while (fd_count < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("frame_done_count", 32'(fd_count), 32'(target));
  endtask

  task automatic wait_sb(input int level, input int budget);
    int n = 0;
    while (sb.size() > level && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("sb_progress", 32'(sb.size() <= level), 32'd1);
  endtask

  task automatic pulse_refresh();
    @(negedge clock);
    refresh = 1'b1;
    @(negedge clock);
    refresh = 1'b0;
  endtask

  // Bus monitor: scoreboard compare on each strobe, stability and width checks
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_en = 1'b0;
      hi_cnt  = 0;
      pending = 1'b0;
    end else begin
      if (lcd_en && !prev_en) begin
        strobes++;
        hi_cnt  = 1;
        cap     = {lcd_rs, lcd_data};
        pending = 1'b1;
        check("sb_not_empty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("write_byte", {23'd0, lcd_rs, lcd_data}, {23'd0, mon_e.rs, mon_e.data});
          if (mon_e.gap != 0)
            check("strobe_gap", 32'(cyc - (mon_e.from_rel ? rel_cyc : last_rise)), 32'(mon_e.gap));
        end
        last_rise = cyc;
      end else if (lcd_en) begin
        hi_cnt++;
        check("strobe_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, cap});
      end else if (prev_en && pending) begin
        check("en_width", 32'(hi_cnt), 32'(ENP));
        check("hold_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, cap});
        pending = 1'b0;
      end
      if (frame_done) begin
        fd_count++;
        check("busy_low_at_done", 32'(busy), 32'd0);
      end
      prev_en = lcd_en;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Frame 1: reset, init sequence, automatic first frame
    addr_in = 5'd7; rw_in = 1'b1; data_in = 8'hA5; data_mem = 8'h3C;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    push_init();
    push_frame(ENP + CMDW + 2, 5'd7, 1'b1, 8'hA5, 8'h3C);
    @(negedge clock);
    reset_n = 1'b1;
    rel_cyc = cyc;
    wait_fd(1, 3000);
    check("sb_empty_f1", 32'(sb.size()), 32'd0);

    // Frame 2: boundary field values, refresh while busy is dropped
    repeat (5) @(negedge clock);
    check("busy_in_idle", 32'(busy), 32'd0);
    addr_in = 5'd31; rw_in = 1'b0; data_in = 8'h00; data_mem = 8'hFF;
    push_frame(0, 5'd31, 1'b0, 8'h00, 8'hFF);
    pulse_refresh();
    wait_sb(20, 2000);
    check("busy_mid_frame", 32'(busy), 32'd1);
    pulse_refresh();
    wait_fd(2, 3000);
    check("sb_empty_f2", 32'(sb.size()), 32'd0);
    strobes_snap = strobes;
    repeat (300) @(negedge clock);
    check("no_extra_frame", 32'(fd_count), 32'd2);
    check("no_extra_strobes", 32'(strobes), 32'(strobes_snap));

    // Frame 3: address changes after the snapshot
    addr_in = 5'd5;
    push_frame(0, 5'd5, 1'b0, 8'h00, 8'hFF);
    pulse_refresh();
    wait_sb(27, 2000);
    addr_in = 5'd12;
    wait_fd(3, 3000);
    check("sb_empty_f3", 32'(sb.size()), 32'd0);

    // Frame 4: new address visible
    push_frame(0, 5'd12, 1'b0, 8'h00, 8'hFF);
    pulse_refresh();
    wait_fd(4, 3000);
    check("sb_empty_f4", 32'(sb.size()), 32'd0);

    // Reset during a strobe, then full re-init and first frame
    push_frame(0, 5'd12, 1'b0, 8'h00, 8'hFF);
    pulse_refresh();
    wait_sb(30, 2000);
    begin
      int n = 0;
      do begin
        @(posedge clock);
        #1;
        n++;
      end while (!lcd_en && n < 200);
    end
    check("en_before_reset", 32'(lcd_en), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("en_async_drop", 32'(lcd_en), 32'd0);
    sb.delete();
    repeat (3) @(negedge clock);
    check_reset_vals("reset2");
    addr_in = 5'd19; rw_in = 1'b1; data_in = 8'h9E; data_mem = 8'h40;
    push_init();
    push_frame(ENP + CMDW + 2, 5'd19, 1'b1, 8'h9E, 8'h40);
    @(negedge clock);
    reset_n = 1'b1;
    rel_cyc = cyc;
    wait_fd(5, 3000);
    check("sb_empty_f5", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
